// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared owner/state enums and width defaults for the memory arbiter
package riscv_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-input round-robin picker; bit 0 = fetch, bit 1 = data
module rr_arb2
    import riscv_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);

    // on conflict the side that did not win last time goes first
    assign gnt[0] = req[0] && (!req[1] || last == DATA);
    assign gnt[1] = req[1] && (!req[0] || last == FETCH);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port synchronous memory between fetch and load/store,
// one grant per cycle, response routed back to its owner one cycle later
module imem_dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic [1:0] gnt;
    logic       grant;
    state_t     state_q, state_d;
    owner_t     rsp_owner_q, rsp_owner_d;
    owner_t     last_grant_q, last_grant_d;
    logic       rsp_is_wr_q, rsp_is_wr_d;

    // grants are suppressed while reset is held so every output reads 0
    rr_arb2 u_arb (
        .req  ({dm_req, if_req} & {2{rst}}),
        .last (last_grant_q),
        .gnt  (gnt)
    );

    assign if_gnt = gnt[0];
    assign dm_gnt = gnt[1];
    assign grant  = |gnt;

    always_comb begin
        mem_en       = grant;
        mem_we       = gnt[1] && dm_we;
        mem_addr     = gnt[1] ? dm_addr : gnt[0] ? if_addr : '0;
        mem_wdata    = gnt[1] ? dm_wdata : '0;
        mem_be       = gnt[1] ? dm_be : gnt[0] ? '1 : '0;
        state_d      = grant ? RESP : IDLE;
        rsp_owner_d  = grant ? (gnt[1] ? DATA : FETCH) : rsp_owner_q;
        last_grant_d = grant ? (gnt[1] ? DATA : FETCH) : last_grant_q;
        rsp_is_wr_d  = grant ? (gnt[1] && dm_we) : rsp_is_wr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            rsp_owner_q  <= FETCH;
            last_grant_q <= FETCH;
            rsp_is_wr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_owner_q  <= rsp_owner_d;
            last_grant_q <= last_grant_d;
            rsp_is_wr_q  <= rsp_is_wr_d;
        end
    end

    // read data passes straight through from the macro; store acks return 0
    always_comb begin
        if_rvalid = state_q == RESP && rsp_owner_q == FETCH;
        dm_rvalid = state_q == RESP && rsp_owner_q == DATA;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = (dm_rvalid && !rsp_is_wr_q) ? mem_rdata : '0;
    end

endmodule
